wave_dac_spi_driver: RTL and testbench

Downstream stage of the waveform generator. It takes each 8-bit waveform sample through a valid/ready handshake and frames it into a 16-bit word. The word is shifted MSB-first to an external serial DAC over a 3-wire SPI-style interface (SCLK, MOSI, CS_n). It runs in the same 100 kHz domain as the generator and counts samples that arrive while a frame is still in flight.

---
 rtl/wave_dac_spi_driver.sv | 138 +++++++++++++
 tb/tb_wave_dac_spi_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wave_dac_spi_driver.sv
// wave_dac_spi_driver: accepts 8-bit waveform samples over valid/ready and
// shifts each one MSB-first to a serial DAC as {CMD, sample, 4'b0000}.
// SCLK idles low; MOSI changes on falling SCLK edges so it is stable for a
// full SCLK period around every rising edge, where the DAC samples it.
module wave_dac_spi_driver #(
    parameter int unsigned CLK_DIV = 1,        // clk cycles per SCLK half-period (1..255)
    parameter logic [3:0]  CMD     = 4'b0011,  // DAC command nibble, frame bits [15:12]
    parameter int unsigned CS_GAP  = 2         // clk cycles CS_n stays high between frames (1..15)
) (
    input  logic       clk_100kHz,
    input  logic       rst_,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       dac_cs_n,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);
    localparam logic [5:0] TOG_END  = 6'd32;

    state_t      r_state;
    logic [15:0] r_shift;
    logic [7:0]  r_div_cnt;
    logic [5:0]  r_tog_cnt;
    logic [3:0]  r_gap_cnt;
    logic        r_ready;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_drop;

    logic [5:0]  w_tog_next;
    logic        w_accept;

    assign w_tog_next = r_tog_cnt + 6'd1;
    // Handshake uses the registered ready, so the edge where ready returns is not an accept.
    assign w_accept   = sample_valid && r_ready;

    // Frame sequencer: IDLE -> SHIFT (32 SCLK toggles) -> GAP (CS_n high) -> IDLE.
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_IDLE;
            r_shift   <= 16'h0000;
            r_div_cnt <= 8'd0;
            r_tog_cnt <= 6'd0;
            r_gap_cnt <= 4'd0;
            r_ready   <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= {CMD, sample_in, 4'b0000};
                        r_mosi    <= CMD[3];
                        r_cs_n    <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        r_div_cnt <= 8'd0;
                        r_tog_cnt <= 6'd0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= 8'd0;
                        r_tog_cnt <= w_tog_next;
                        if (w_tog_next == TOG_END) begin
                            // Last falling edge closes the frame.
                            r_sclk    <= 1'b0;
                            r_mosi    <= 1'b0;
                            r_cs_n    <= 1'b1;
                            r_done    <= 1'b1;
                            r_gap_cnt <= 4'd0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_sclk <= ~r_sclk;
                            // Even toggles are falling edges: present the next bit.
                            if (!w_tog_next[0]) begin
                                r_shift <= {r_shift[14:0], 1'b0};
                                r_mosi  <= r_shift[14];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Overrun counter: every offered-but-not-ready edge, saturating at 255.
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            r_drop <= 8'd0;
        end else if (sample_valid && !r_ready && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign sample_ready = r_ready;
    assign dac_sclk     = r_sclk;
    assign dac_mosi     = r_mosi;
    assign dac_cs_n     = r_cs_n;
    assign busy         = r_busy;
    assign frame_done   = r_done;
    assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_wave_dac_spi_driver.sv
// Directed bench for wave_dac_spi_driver: instance A at CLK_DIV=1/CS_GAP=2,
// instance B at CLK_DIV=3/CS_GAP=4. A DAC-side monitor captures MOSI on
// every rising SCLK edge; edges are numbered from the accept edge (edge 0).
module tb_wave_dac_spi_driver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] a_sample, b_sample;
    logic       a_valid, b_valid;
    logic       a_ready, a_sclk, a_mosi, a_csn, a_busy, a_done;
    logic       b_ready, b_sclk, b_mosi, b_csn, b_busy, b_done;
    logic [7:0] a_drop, b_drop;

    int n_cmp = 0;
    int n_err = 0;

    wave_dac_spi_driver #(.CLK_DIV(1), .CMD(4'b0011), .CS_GAP(2)) u_a (
        .clk_100kHz(clk), .rst_(rst_n), .sample_in(a_sample), .sample_valid(a_valid),
        .sample_ready(a_ready), .dac_sclk(a_sclk), .dac_mosi(a_mosi), .dac_cs_n(a_csn),
        .busy(a_busy), .frame_done(a_done), .drop_cnt(a_drop));

    wave_dac_spi_driver #(.CLK_DIV(3), .CMD(4'b0011), .CS_GAP(4)) u_b (
        .clk_100kHz(clk), .rst_(rst_n), .sample_in(b_sample), .sample_valid(b_valid),
        .sample_ready(b_ready), .dac_sclk(b_sclk), .dac_mosi(b_mosi), .dac_cs_n(b_csn),
        .busy(b_busy), .frame_done(b_done), .drop_cnt(b_drop));

    // DAC-side capture: shift in MOSI on each rising SCLK
    logic [15:0] a_word = 16'h0, b_word = 16'h0;
    int a_rise = 0, b_rise = 0, a_done_cnt = 0;
    always @(posedge a_sclk) begin a_word <= {a_word[14:0], a_mosi}; a_rise <= a_rise + 1; end
    always @(posedge b_sclk) begin b_word <= {b_word[14:0], b_mosi}; b_rise <= b_rise + 1; end
    always @(negedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

    task automatic test_reset();
        int r0;
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_sample = 8'h00; b_sample = 8'h00;
        #10;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        n_cmp++; if (a_csn !== 1'b1) begin n_err++; $display("FAIL reset_csn: got %b want 1", a_csn); end
        n_cmp++; if (a_sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
        n_cmp++; if (a_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
        n_cmp++; if (a_drop !== 8'h00) begin n_err++; $display("FAIL reset_drop: got %h want 00", a_drop); end
        n_cmp++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b want 00", a_busy, a_done); end
        r0 = a_rise;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (a_rise != r0 || a_csn !== 1'b1) begin n_err++; $display("FAIL reset_idle_quiet: rises %0d csn %b want 0 rises csn 1", a_rise - r0, a_csn); end
    endtask

    task automatic test_single();
        int r0, d0;
        r0 = a_rise; d0 = a_done_cnt;
        a_sample = 8'hA5; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; a_sample = 8'h00;
        n_cmp++; if (a_busy !== 1'b1 || a_csn !== 1'b0 || a_ready !== 1'b0) begin n_err++; $display("FAIL single_accept: busy %b csn %b ready %b want 1 0 0", a_busy, a_csn, a_ready); end
        n_cmp++; if (a_mosi !== 1'b0 || a_sclk !== 1'b0) begin n_err++; $display("FAIL single_first_bit: mosi %b sclk %b want 0 0", a_mosi, a_sclk); end
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin n_cmp++; if (a_sclk !== 1'b1) begin n_err++; $display("FAIL single_first_rise: got %b want 1", a_sclk); end end
            if (k == 31) begin n_cmp++; if (a_csn !== 1'b0 || a_done !== 1'b0) begin n_err++; $display("FAIL single_e31: csn %b done %b want 0 0", a_csn, a_done); end end
            if (k == 32) begin n_cmp++; if (a_csn !== 1'b1 || a_done !== 1'b1 || a_sclk !== 1'b0) begin n_err++; $display("FAIL single_e32: csn %b done %b sclk %b want 1 1 0", a_csn, a_done, a_sclk); end end
            if (k == 33) begin n_cmp++; if (a_ready !== 1'b0 || a_done !== 1'b0) begin n_err++; $display("FAIL single_e33: ready %b done %b want 0 0", a_ready, a_done); end end
            if (k == 34) begin n_cmp++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin n_err++; $display("FAIL single_e34: ready %b busy %b want 1 0", a_ready, a_busy); end end
        end
        n_cmp++; if (a_word !== 16'h3A50) begin n_err++; $display("FAIL single_word: got %h want 3a50", a_word); end
        n_cmp++; if (a_rise - r0 != 16) begin n_err++; $display("FAIL single_rises: got %0d want 16", a_rise - r0); end
        n_cmp++; if (a_done_cnt - d0 != 1) begin n_err++; $display("FAIL single_done_pulses: got %0d want 1", a_done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] snap;
        snap = a_drop;
        a_sample = 8'h00; a_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept0: busy %b want 1", a_busy); end
        a_sample = 8'hFF;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            if (k == 34) begin n_cmp++; if (a_ready !== 1'b1 || a_drop !== 8'(snap + 8'd34)) begin n_err++; $display("FAIL b2b_e34: ready %b drop %h want 1 %h", a_ready, a_drop, 8'(snap + 8'd34)); end end
            if (k == 35) begin
                n_cmp++; if (a_busy !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept1: busy %b ready %b want 1 0", a_busy, a_ready); end
                n_cmp++; if (a_word !== 16'h3000) begin n_err++; $display("FAIL b2b_word00: got %h want 3000", a_word); end
                n_cmp++; if (a_drop !== 8'(snap + 8'd34)) begin n_err++; $display("FAIL b2b_drop_on_accept: got %h want %h", a_drop, 8'(snap + 8'd34)); end
            end
        end
        a_sample = 8'h55;
        for (int k = 1; k <= 34; k++) begin @(posedge clk); #1; end
        a_valid = 1'b0;
        n_cmp++; if (a_word !== 16'h3FF0) begin n_err++; $display("FAIL b2b_wordFF: got %h want 3ff0", a_word); end
        n_cmp++; if (a_ready !== 1'b1 || a_drop !== 8'(snap + 8'd68)) begin n_err++; $display("FAIL b2b_end: ready %b drop %h want 1 %h", a_ready, a_drop, 8'(snap + 8'd68)); end
    endtask

    task automatic test_saturation();
        logic [7:0] prev;
        int dec, n;
        dec = 0; prev = a_drop;
        a_sample = 8'h12; a_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (a_drop < prev) dec++;
            prev = a_drop;
        end
        a_valid = 1'b0;
        n_cmp++; if (a_drop !== 8'hFF) begin n_err++; $display("FAIL sat_value: got %h want ff", a_drop); end
        n_cmp++; if (dec != 0) begin n_err++; $display("FAIL sat_nowrap: decreases %0d want 0", dec); end
        n = 0;
        while (a_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL sat_idle_timeout: ready %b want 1", a_ready); end
    endtask

    task automatic test_reset_midframe();
        int r0, n;
        r0 = a_rise;
        a_sample = 8'h77; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        n = 0;
        while ((a_rise - r0) < 7 && n < 100) begin @(posedge clk); #1; n++; end
        n_cmp++; if (a_rise - r0 != 7 || a_sclk !== 1'b1 || a_mosi !== 1'b1 || a_csn !== 1'b0) begin n_err++; $display("FAIL mid_pre: rises %0d sclk %b mosi %b csn %b want 7 1 1 0", a_rise - r0, a_sclk, a_mosi, a_csn); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_csn !== 1'b1 || a_sclk !== 1'b0 || a_mosi !== 1'b0) begin n_err++; $display("FAIL mid_async: csn %b sclk %b mosi %b want 1 0 0", a_csn, a_sclk, a_mosi); end
        n_cmp++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_drop !== 8'h00) begin n_err++; $display("FAIL mid_async_state: ready %b busy %b drop %h want 1 0 00", a_ready, a_busy, a_drop); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        r0 = a_rise;
        a_sample = 8'h3C; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        n_cmp++; if (a_word !== 16'h33C0 || a_rise - r0 != 16) begin n_err++; $display("FAIL mid_next_frame: word %h rises %0d want 33c0 16", a_word, a_rise - r0); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL mid_next_ready: got %b want 1", a_ready); end
    endtask

    task automatic test_clkdiv3();
        int r0;
        r0 = b_rise;
        b_sample = 8'h81; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0; b_sample = 8'hFF;
        n_cmp++; if (b_busy !== 1'b1 || b_csn !== 1'b0) begin n_err++; $display("FAIL div3_accept: busy %b csn %b want 1 0", b_busy, b_csn); end
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin n_cmp++; if (b_sclk !== 1'b0) begin n_err++; $display("FAIL div3_e2_sclk: got %b want 0", b_sclk); end end
            if (k == 3) begin n_cmp++; if (b_sclk !== 1'b1) begin n_err++; $display("FAIL div3_e3_sclk: got %b want 1", b_sclk); end end
            if (k == 5) begin n_cmp++; if (b_sclk !== 1'b1) begin n_err++; $display("FAIL div3_e5_sclk: got %b want 1", b_sclk); end end
            if (k == 6) begin n_cmp++; if (b_sclk !== 1'b0) begin n_err++; $display("FAIL div3_e6_sclk: got %b want 0", b_sclk); end end
            if (k == 95) begin n_cmp++; if (b_csn !== 1'b0) begin n_err++; $display("FAIL div3_e95_csn: got %b want 0", b_csn); end end
            if (k == 96) begin n_cmp++; if (b_csn !== 1'b1 || b_done !== 1'b1) begin n_err++; $display("FAIL div3_e96: csn %b done %b want 1 1", b_csn, b_done); end end
            if (k == 99) begin n_cmp++; if (b_ready !== 1'b0 || b_csn !== 1'b1) begin n_err++; $display("FAIL div3_e99: ready %b csn %b want 0 1", b_ready, b_csn); end end
            if (k == 100) begin n_cmp++; if (b_ready !== 1'b1 || b_busy !== 1'b0) begin n_err++; $display("FAIL div3_e100: ready %b busy %b want 1 0", b_ready, b_busy); end end
        end
        n_cmp++; if (b_word !== 16'h3810 || b_rise - r0 != 16) begin n_err++; $display("FAIL div3_word: word %h rises %0d want 3810 16", b_word, b_rise - r0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        test_clkdiv3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
